// File: rtl/cic_decim_ctrl_pkg.sv
// Shared types and rate bounds for the CIC decimator controller.
package cic_decim_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int MIN_RATE = 2;

  function automatic logic rate_legal(input int r, input int max_r);
    return (r >= MIN_RATE) && (r <= max_r);
  endfunction
endpackage

// File: rtl/cic_decim_rate_cnt.sv
// Sample counter with wrap compare and a pending-rate register that is
// swapped in only at a frame boundary, so a frame never runs at a mixed rate.
module cic_decim_rate_cnt
  import cic_decim_ctrl_pkg::*;
#(
  parameter int MAXRATE   = 1000,
  parameter int CNT_WIDTH = 10,
  parameter int DEFRATE   = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 acc_i,
  input  logic                 clr_i,
  input  logic                 sync_i,
  input  logic                 rate_ld_i,
  input  logic [CNT_WIDTH-1:0] rate_i,
  output logic                 wrap_o,
  output logic                 ld_err_o,
  output logic [CNT_WIDTH-1:0] rate_o
);
  localparam logic [CNT_WIDTH-1:0] DEF_R = CNT_WIDTH'(DEFRATE);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, rate_q, pend_q, eff_r;
  logic                 pend_v_q, ld_ok, eff_v, apply;

  assign ld_ok    = rate_ld_i && rate_legal(int'(rate_i), MAXRATE);
  assign ld_err_o = rate_ld_i && !ld_ok;
  // A load arriving this cycle counts as already pending, so it can be
  // applied by a coincident wrap, sync or idle-zero boundary.
  assign eff_v    = pend_v_q || ld_ok;
  assign eff_r    = ld_ok ? rate_i : pend_q;
  assign wrap_o   = acc_i && (cnt_q == rate_q - ONE);
  assign apply    = eff_v && (wrap_o || sync_i || ((cnt_q == '0) && !acc_i));
  assign rate_o   = rate_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      rate_q   <= DEF_R;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      if (sync_i || clr_i)
        cnt_q <= '0;
      else if (acc_i)
        cnt_q <= wrap_o ? '0 : cnt_q + ONE;

      if (apply) begin
        rate_q   <= eff_r;
        pend_v_q <= 1'b0;
      end else if (ld_ok) begin
        pend_q   <= rate_i;
        pend_v_q <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/cic_decim_ctrl.sv
// Run/idle control for a CIC decimator: generates the input activity and
// decimation strobes, tracks the active rate and flags rejected rate loads.
module cic_decim_ctrl
  import cic_decim_ctrl_pkg::*;
#(
  parameter int MAXRATE   = 1000,
  parameter int CNT_WIDTH = 10,
  parameter int DEFRATE   = 1000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 valid_i,
  input  logic [CNT_WIDTH-1:0] rate_i,
  input  logic                 rate_ld_i,
  input  logic                 sync_i,
  input  logic                 cic_val_i,
  output logic                 act_o,
  output logic                 act_out_o,
  output logic                 val_o,
  output logic [CNT_WIDTH-1:0] rate_o,
  output logic                 err_o
);
  state_t state_q, state_d;
  logic   run, acc, clr, wrap, ld_err;
  logic   act_q, act_out_q, val_q, err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RUN;
      RUN:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The exit cycle (RUN with en_i low) accepts no sample, so act_o is
  // never seen high once the FSM is back in IDLE.
  always_comb begin
    run = (state_q == RUN);
    acc = run && en_i && valid_i;
    clr = run && !en_i;
  end

  cic_decim_rate_cnt #(
    .MAXRATE  (MAXRATE),
    .CNT_WIDTH(CNT_WIDTH),
    .DEFRATE  (DEFRATE)
  ) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .acc_i    (acc),
    .clr_i    (clr),
    .sync_i   (sync_i),
    .rate_ld_i(rate_ld_i),
    .rate_i   (rate_i),
    .wrap_o   (wrap),
    .ld_err_o (ld_err),
    .rate_o   (rate_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_q     <= 1'b0;
      act_out_q <= 1'b0;
      val_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      act_q     <= acc;
      act_out_q <= wrap && !sync_i;
      val_q     <= cic_val_i && (state_d == RUN);
      err_q     <= err_q || ld_err;
    end
  end

  assign act_o     = act_q;
  assign act_out_o = act_out_q;
  assign val_o     = val_q;
  assign err_o     = err_q;
endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter MAXRATE, default 1000: largest legal decimation rate R.
REQ-002 SHALL have parameter CNT_WIDTH, default 10: width of rate and counter; SHALL satisfy 2**CNT_WIDTH >= MAXRATE.
REQ-003 SHALL have parameter DEFRATE, default 1000: rate loaded at reset; 2 <= DEFRATE <= MAXRATE.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port en_i, input, 1: run enable.
REQ-007 SHALL have port valid_i, input, 1: upstream sample valid strobe.
REQ-008 SHALL have port rate_i, input, CNT_WIDTH: requested decimation rate R.
REQ-009 SHALL have port rate_ld_i, input, 1: one-cycle request to load rate_i.
REQ-010 SHALL have port sync_i, input, 1: phase realign request.
REQ-011 SHALL have port cic_val_i, input, 1: output-valid strobe returned by the CIC.
REQ-012 SHALL have port act_o, output, 1: CIC input activity strobe (drives act_i).
REQ-013 SHALL have port act_out_o, output, 1: CIC decimation strobe (drives act_out_i).
REQ-014 SHALL have port val_o, output, 1: registered copy of cic_val_i, gated by RUN.
REQ-015 SHALL have port rate_o, output, CNT_WIDTH: currently active rate.
REQ-016 SHALL have port err_o, output, 1: sticky flag, rejected rate load.

Function
REQ-017 FSM states SHALL be IDLE, RUN; IDLE->RUN when en_i=1; RUN->IDLE when en_i=0; entering IDLE clears the counter.
REQ-018 In RUN, act_o SHALL equal valid_i registered one cycle (1-cycle latency); in IDLE act_o SHALL be 0.
REQ-019 Counter SHALL increment on each accepted sample (valid_i=1 in RUN); on accepted sample with count = rate_o-1 it SHALL wrap to 0 and assert act_out_o coincident with that sample's act_o.
REQ-020 act_out_o SHALL be a single-cycle pulse and never asserted without act_o.
REQ-021 rate_ld_i with 2 <= rate_i <= MAXRATE SHALL latch rate_i into a pending register; pending rate SHALL become rate_o on the cycle after the next wrap, or immediately (next cycle) if the counter is 0 and no sample is accepted that cycle.
REQ-022 A second legal rate_ld_i before application SHALL overwrite the pending value.
REQ-023 rate_ld_i with rate_i < 2 or > MAXRATE SHALL be ignored and SHALL set err_o; err_o clears only on reset.
REQ-024 sync_i SHALL clear the counter to 0 next cycle without asserting act_out_o; a pending rate SHALL be applied at that point.
REQ-025 sync_i coincident with a wrapping sample SHALL suppress that act_out_o (sync wins).
REQ-026 rate_ld_i and sync_i simultaneous: load evaluated first, then sync applies it.
REQ-027 val_o SHALL equal cic_val_i delayed one cycle, forced 0 in IDLE.

Reset
REQ-028 rst_i asserted SHALL immediately force state IDLE, counter 0, act_o 0, act_out_o 0, val_o 0, err_o 0, pending flag 0, rate_o DEFRATE.
REQ-029 Reset mid-frame SHALL discard partial count and pending rate; after deassertion the first act_out_o SHALL occur on the DEFRATE-th accepted sample.

Structure
REQ-030 A shared package SHALL hold the FSM state type and rate-bound constants (minimum rate 2).
REQ-031 One sub-module, cic_decim_rate_cnt (counter + wrap compare + pending-rate register), is natural; the FSM and output registers stay in the top.

Verification
REQ-032 DEFRATE=4, en_i=1, valid_i continuous -> act_out_o on samples 4, 8, 12; rate_o=4.
REQ-033 valid_i every 2nd cycle, R=4 -> act_out_o every 8 cycles, always coincident with act_o.
REQ-034 rate_ld_i rate_i=6 after sample 2 of a R=4 frame -> wrap at sample 4, next act_out_o 6 samples later, rate_o=6.
REQ-035 sync_i after sample 3 (R=4) -> no act_out_o on sample 4; next act_out_o on 4th sample after sync.
REQ-036 rate_ld_i with rate_i=1 and rate_i=1001 -> rate_o unchanged, err_o=1 until rst_i.
REQ-037 rst_i pulsed asynchronously mid-frame with pending rate 8 -> outputs 0 within the same cycle, rate_o=DEFRATE, first act_out_o on DEFRATE-th sample.
